combo_lock: RTL and testbench
=============================

COMBO_LOCK -- requirements
Module: combo_lock

Interface
REQ-001 Parameter RESET_CODE, default 32'h0000_0000, code loaded into the stored-code register on reset.
REQ-002 Parameter MAX_FAILS, default 3, failed entries (1..15) that trigger lockout.
REQ-003 Parameter LOCKOUT_CYCLES, default 16, lockout duration in clk cycles (>=1).
REQ-004 Parameter IDLE_TIMEOUT, default 8, max idle cycles between bytes of one entry (>=1).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 din  input  8  entry byte; sampled only when din_valid=1.
REQ-008 din_valid  input  1  din qualifier; one byte per cycle when high, no backpressure.
REQ-009 relock  input  1  single-cycle pulse; relocks or aborts entry.
REQ-010 code_in  input  32  new code value.
REQ-011 code_we  input  1  write strobe for code_in.
REQ-012 unlocked  output  1  high while in OPEN.
REQ-013 lockout  output  1  high while in LOCKOUT.
REQ-014 fail_count  output  4  current consecutive failed-entry count.

Function
REQ-015 FSM states IDLE, COLLECT, OPEN, LOCKOUT; all outputs registered.
REQ-016 Entry = 4 valid bytes, MSB first: byte0 vs code[31:24], byte1 vs [23:16], byte2 vs [15:8], byte3 vs [7:0].
REQ-017 IDLE: din_valid=1 -> compare byte0, set byte index 1, go COLLECT.
REQ-018 COLLECT: each din_valid=1 compares next byte; mismatch sets sticky error flag; remaining bytes still consumed.
REQ-019 On 4th byte edge with no mismatch: next cycle unlocked=1, state OPEN, fail_count=0 (one-cycle latency from 4th byte sample).
REQ-020 On 4th byte edge with any mismatch: fail_count+1 (saturating at 15); if new count >= MAX_FAILS -> LOCKOUT, else IDLE.
REQ-021 COLLECT: IDLE_TIMEOUT consecutive cycles with din_valid=0 -> discard partial entry, return IDLE, fail_count unchanged; timer reloads on each valid byte.
REQ-022 COLLECT: relock=1 aborts entry -> IDLE, fail_count unchanged; relock wins over same-cycle din_valid.
REQ-023 OPEN: din_valid ignored; relock=1 -> IDLE, unlocked=0 next cycle.
REQ-024 code_we accepted only in OPEN; stored code <= code_in on that edge; ignored in all other states.
REQ-025 code_we and relock same cycle in OPEN: both take effect (code updated, state IDLE).
REQ-026 LOCKOUT: din_valid, relock, code_we ignored; exits to IDLE after exactly LOCKOUT_CYCLES cycles with lockout=1, fail_count cleared on exit.
REQ-027 Error flag and byte index cleared on every entry start, abort, timeout and completion.
REQ-028 Back-to-back entries: a valid byte in the cycle after a failed entry returning to IDLE starts a new entry.

Reset
REQ-029 reset=1 asynchronously forces IDLE, unlocked=0, lockout=0, fail_count=0, byte index 0, error flag 0, timers 0, stored code=RESET_CODE.
REQ-030 Reset mid-entry, in OPEN or in LOCKOUT abandons all progress; no byte sampled while reset=1.
REQ-031 First byte accepted on first rising edge after reset deasserts.

Verification (RESET_CODE=32'hbaadc0de, MAX_FAILS=3, LOCKOUT_CYCLES=16, IDLE_TIMEOUT=8)
REQ-032 Bytes ba,ad,c0,de on 4 consecutive cycles -> unlocked=1 from the cycle after de, fail_count=0.
REQ-033 Bytes ba,ad,c0,df three times -> fail_count 1,2 then 3 with lockout=1 for 16 cycles; correct code sent during lockout leaves unlocked=0; fail_count=0 after exit.
REQ-034 Bytes ba,ad, then 8 idle cycles, then ba,ad,c0,de -> unlocked=1, fail_count=0 (partial entry discarded, not counted).
REQ-035 Unlock, code_we with code_in=32'h12345678, relock; entry ba,ad,c0,de -> fail_count=1; entry 12,34,56,78 -> unlocked=1.
REQ-036 Reset asserted mid-entry after ba,ad -> outputs zero immediately; subsequent c0,de then ba,ad,c0,de -> first entry fails at 4th byte (fail_count=1) is not required; bench checks c0,de,ba,ad yields fail_count=1 and a following ba,ad,c0,de unlocks.

Source files
------------

// File: rtl/combo_lock.sv
// Four-byte combination lock with failed-entry lockout, idle timeout and a code
// register that can only be rewritten while open.
//
//   state     | meaning
//   S_IDLE    | waiting for the first byte of an entry
//   S_COLLECT | bytes 1..3 of an entry being compared
//   S_OPEN    | correct code entered; code may be rewritten
//   S_LOCKOUT | too many failures; all inputs ignored until timer expires
module combo_lock #(
    parameter logic [31:0] RESET_CODE     = 32'h0000_0000,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 16,
    parameter int          IDLE_TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        relock,
    input  logic [31:0] code_in,
    input  logic        code_we,
    output logic        unlocked,
    output logic        lockout,
    output logic [3:0]  fail_count
);

    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_RELOAD = IW'(IDLE_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_RELOAD = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    FAIL_LIMIT  = 4'(MAX_FAILS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t        state;
    logic [31:0]   code;
    logic [1:0]    byte_idx;
    logic          err;
    logic [IW-1:0] idle_tmr;
    logic [LW-1:0] lock_tmr;

    logic [7:0]    exp_byte;
    logic          byte_ok;
    logic [3:0]    fail_next;

    always_comb begin
        exp_byte = code[7:0];
        case (byte_idx)
            2'd0:    exp_byte = code[31:24];
            2'd1:    exp_byte = code[23:16];
            2'd2:    exp_byte = code[15:8];
            default: exp_byte = code[7:0];
        endcase
        byte_ok   = (din == exp_byte);
        fail_next = (fail_count == 4'hf) ? 4'hf : fail_count + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            code       <= RESET_CODE;
            byte_idx   <= 2'd0;
            err        <= 1'b0;
            idle_tmr   <= '0;
            lock_tmr   <= '0;
            unlocked   <= 1'b0;
            lockout    <= 1'b0;
            fail_count <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (din_valid) begin
                        err      <= !byte_ok;
                        byte_idx <= 2'd1;
                        idle_tmr <= IDLE_RELOAD;
                        state    <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    // relock outranks a byte arriving in the same cycle
                    if (relock) begin
                        byte_idx <= 2'd0;
                        err      <= 1'b0;
                        state    <= S_IDLE;
                    end else if (din_valid) begin
                        idle_tmr <= IDLE_RELOAD;
                        if (byte_idx == 2'd3) begin
                            byte_idx <= 2'd0;
                            err      <= 1'b0;
                            if (err || !byte_ok) begin
                                fail_count <= fail_next;
                                if (fail_next >= FAIL_LIMIT) begin
                                    lock_tmr <= LOCK_RELOAD;
                                    lockout  <= 1'b1;
                                    state    <= S_LOCKOUT;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                fail_count <= 4'd0;
                                unlocked   <= 1'b1;
                                state      <= S_OPEN;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            err      <= err || !byte_ok;
                        end
                    end else if (idle_tmr == '0) begin
                        byte_idx <= 2'd0;
                        err      <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        idle_tmr <= idle_tmr - IW'(1);
                    end
                end

                S_OPEN: begin
                    if (code_we) begin
                        code <= code_in;
                    end
                    if (relock) begin
                        unlocked <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                S_LOCKOUT: begin
                    if (lock_tmr == '0) begin
                        lockout    <= 1'b0;
                        fail_count <= 4'd0;
                        state      <= S_IDLE;
                    end else begin
                        lock_tmr <= lock_tmr - LW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_combo_lock.sv
// Scripted bench for combo_lock: expectations are queued as stimulus is driven
// and popped against the registered outputs at the following falling edge.
module tb_combo_lock;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic        din_valid;
    logic        relock;
    logic [31:0] code_in;
    logic        code_we;
    logic        unlocked;
    logic        lockout;
    logic [3:0]  fail_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic       unl;
        logic       lo;
        logic [3:0] fc;
    } exp_t;

    exp_t exp_q[$];

    combo_lock #(
        .RESET_CODE    (32'hbaadc0de),
        .MAX_FAILS     (3),
        .LOCKOUT_CYCLES(16),
        .IDLE_TIMEOUT  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .relock    (relock),
        .code_in   (code_in),
        .code_we   (code_we),
        .unlocked  (unlocked),
        .lockout   (lockout),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic u, input logic l, input logic [3:0] f);
        exp_t e;
        e.tag = tag;
        e.unl = u;
        e.lo  = l;
        e.fc  = f;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".unlocked"},   {31'd0, unlocked}, {31'd0, e.unl});
            chk({e.tag, ".lockout"},    {31'd0, lockout},  {31'd0, e.lo});
            chk({e.tag, ".fail_count"}, {28'd0, fail_count}, {28'd0, e.fc});
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        relock    = 1'b0;
        code_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            relock    = 1'b0;
            code_we   = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] c);
        drive(c[31:24]);
        drive(c[23:16]);
        drive(c[15:8]);
        drive(c[7:0]);
    endtask

    task automatic settle_check(input string tag, input logic u, input logic l, input logic [3:0] f);
        expect_out(tag, u, l, f);
        idle(1);
        check_out();
    endtask

    task automatic now_check(input string tag, input logic u, input logic l, input logic [3:0] f);
        expect_out(tag, u, l, f);
        check_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        relock    = 1'b0;
        code_in   = 32'h0;
        code_we   = 1'b0;

        repeat (2) @(negedge clk);
        now_check("reset", 1'b0, 1'b0, 4'd0);

        // first byte driven as reset releases is taken on the very next edge
        @(negedge clk);
        reset     = 1'b0;
        din       = 8'hba;
        din_valid = 1'b1;
        drive(8'had);
        drive(8'hc0);
        drive(8'hde);
        now_check("unlock_latency", 1'b0, 1'b0, 4'd0);
        settle_check("unlock", 1'b1, 1'b0, 4'd0);

        @(negedge clk);
        relock = 1'b1;
        din_valid = 1'b0;
        settle_check("relock_open", 1'b0, 1'b0, 4'd0);

        // three failures, the last two back to back, lead to lockout
        send(32'hbaadc0df);
        settle_check("fail1", 1'b0, 1'b0, 4'd1);
        send(32'hbaadc0df);
        drive(8'hba);
        now_check("fail2", 1'b0, 1'b0, 4'd2);
        drive(8'had);
        drive(8'hc0);
        drive(8'hdf);
        settle_check("fail3_lockout", 1'b0, 1'b1, 4'd3);
        send(32'hbaadc0de);
        settle_check("lockout_ignores_code", 1'b0, 1'b1, 4'd3);
        @(negedge clk);
        din_valid = 1'b0;
        relock    = 1'b1;
        code_we   = 1'b1;
        code_in   = 32'h1111_1111;
        idle(9);
        now_check("lockout_last_cycle", 1'b0, 1'b1, 4'd3);
        settle_check("lockout_exit", 1'b0, 1'b0, 4'd0);

        // idle timeout discards a partial entry without counting it
        send(32'hbaadc0df);
        settle_check("fail_pre_timeout", 1'b0, 1'b0, 4'd1);
        drive(8'hba);
        drive(8'had);
        idle(8);
        now_check("timeout_no_count", 1'b0, 1'b0, 4'd1);
        send(32'hbaadc0de);
        settle_check("unlock_after_timeout", 1'b1, 1'b0, 4'd0);

        @(negedge clk);
        relock = 1'b1;
        din_valid = 1'b0;
        settle_check("relock2", 1'b0, 1'b0, 4'd0);
        drive(8'hba);
        drive(8'had);
        idle(7);
        drive(8'hc0);
        drive(8'hde);
        settle_check("gap_below_timeout", 1'b1, 1'b0, 4'd0);

        send(32'hbaadc0df);
        settle_check("open_ignores_din", 1'b1, 1'b0, 4'd0);

        // code rewrite and relock in the same cycle both take effect
        @(negedge clk);
        din_valid = 1'b0;
        code_we   = 1'b1;
        code_in   = 32'h1234_5678;
        relock    = 1'b1;
        settle_check("write_relock", 1'b0, 1'b0, 4'd0);
        send(32'hbaadc0de);
        settle_check("old_code_fails", 1'b0, 1'b0, 4'd1);
        send(32'h1234_5678);
        settle_check("new_code_unlocks", 1'b1, 1'b0, 4'd0);

        @(negedge clk);
        relock = 1'b1;
        din_valid = 1'b0;
        settle_check("relock3", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        code_we = 1'b1;
        code_in = 32'hdead_beef;
        drive(8'h12);
        drive(8'h34);
        @(negedge clk);
        din       = 8'h56;
        din_valid = 1'b1;
        relock    = 1'b1;
        idle(1);
        send(32'h1234_5678);
        settle_check("abort_then_unlock", 1'b1, 1'b0, 4'd0);

        // asynchronous reset while open, then mid-entry
        @(negedge clk);
        reset = 1'b1;
        #1;
        now_check("reset_in_open", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(8'hba);
        drive(8'had);
        @(negedge clk);
        reset     = 1'b1;
        din       = 8'hc0;
        din_valid = 1'b1;
        #1;
        now_check("reset_mid_entry", 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        din   = 8'hc0;
        drive(8'hde);
        drive(8'hba);
        drive(8'had);
        settle_check("post_reset_fail", 1'b0, 1'b0, 4'd1);
        send(32'hbaadc0de);
        settle_check("post_reset_unlock", 1'b1, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
